// File: rtl/dma_arbiter_if.sv
// Memory request bus between the NTT initiators and the DMA memory arbiter.
// The arbiter takes the slave modport; initiators drive the master side.
interface dma_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   logic [NUM_PORTS-1:0]    arb_req;
   logic [NUM_PORTS-1:0]    arb_we;
   logic [NUM_PORTS*48-1:0] arb_addr;
   logic [NUM_PORTS*64-1:0] arb_wdata;
   logic [NUM_PORTS-1:0]    arb_gnt;
   logic [NUM_PORTS-1:0]    arb_valid;
   logic [63:0]             arb_rdata;
   logic                    err_oob;
   logic                    err_clr;
   logic [31:0]             perf_grants;
   logic [31:0]             perf_stalls;

   modport master (
      output arb_req, arb_we, arb_addr, arb_wdata, err_clr,
      input  arb_gnt, arb_valid, arb_rdata, err_oob, perf_grants, perf_stalls
   );

   modport slave (
      input  arb_req, arb_we, arb_addr, arb_wdata, err_clr,
      output arb_gnt, arb_valid, arb_rdata, err_oob, perf_grants, perf_stalls
   );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter onto a single-ported 64-bit memory with fixed read latency.
// Optional grant/stall counters are built only when DMA_ARB_PERF_EN is defined.
module dma_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int AW        = 14,
   parameter int READ_LAT  = 2
) (
   input logic          clk,
   input logic          rst,
   dma_arbiter_if.slave bus
);
   localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int DEPTH = 1 << AW;

   logic [63:0]          mem [DEPTH];
   logic [NUM_PORTS-1:0] gnt_q, busy_q, valid_q, elig;
   logic [PW-1:0]        ptr_q, sel;
   logic                 any_elig;
   logic [63:0]          rdata_q;
   logic                 err_q;
   logic [READ_LAT-1:0]  pv_q;
   logic [63:0]          pd_q [READ_LAT];
   logic [PW-1:0]        pp_q [READ_LAT];

   logic [47:0]          sel_addr;
   logic [63:0]          sel_wdata;
   logic                 sel_we, sel_oob;
   logic [AW-1:0]        sel_idx;
   logic                 unused_lsb;

   // A port is blocked while its grant pulse is high or its read is still in the pipe.
   always_comb begin
      elig     = bus.arb_req & ~gnt_q & ~busy_q;
      sel      = ptr_q;
      any_elig = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         int idx;
         idx = (int'(ptr_q) + i) % NUM_PORTS;
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            sel      = PW'(idx);
         end
      end
   end

   assign sel_addr   = bus.arb_addr[48*int'(sel) +: 48];
   assign sel_wdata  = bus.arb_wdata[64*int'(sel) +: 64];
   assign sel_we     = bus.arb_we[sel];
   assign sel_idx    = sel_addr[AW+2:3];
   assign sel_oob    = |sel_addr[47:AW+3];
   assign unused_lsb = ^sel_addr[2:0];

   always_ff @(posedge clk) begin
      if (!rst && any_elig && sel_we && !sel_oob) begin
         mem[sel_idx] <= sel_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q   <= '0;
         busy_q  <= '0;
         valid_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ptr_q   <= PW'(NUM_PORTS - 1);
         pv_q    <= '0;
         for (int s = 0; s < READ_LAT; s++) begin
            pd_q[s] <= '0;
            pp_q[s] <= '0;
         end
      end else begin
         gnt_q   <= '0;
         valid_q <= '0;
         pv_q[0] <= any_elig && !sel_we;
         pp_q[0] <= sel;
         pd_q[0] <= sel_oob ? 64'd0 : mem[sel_idx];
         for (int s = 1; s < READ_LAT; s++) begin
            pv_q[s] <= pv_q[s-1];
            pp_q[s] <= pp_q[s-1];
            pd_q[s] <= pd_q[s-1];
         end
         // Busy drops on the same edge that raises valid, so the port may request during its valid cycle.
         if (pv_q[READ_LAT-1]) begin
            valid_q[pp_q[READ_LAT-1]] <= 1'b1;
            busy_q[pp_q[READ_LAT-1]]  <= 1'b0;
            rdata_q                   <= pd_q[READ_LAT-1];
         end
         if (any_elig) begin
            gnt_q[sel] <= 1'b1;
            ptr_q      <= sel;
            if (!sel_we) busy_q[sel] <= 1'b1;
         end
         if (any_elig && sel_oob) err_q <= 1'b1;
         else if (bus.err_clr)    err_q <= 1'b0;
      end
   end

   assign bus.arb_gnt   = gnt_q;
   assign bus.arb_valid = valid_q;
   assign bus.arb_rdata = rdata_q;
   assign bus.err_oob   = err_q;

`ifdef DMA_ARB_PERF_EN
   logic [31:0] grants_q, stalls_q;
   logic        stall;

   // At most one grant per cycle, so a stall is simply two or more eligible ports.
   assign stall = $countones(elig) > 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grants_q <= '0;
         stalls_q <= '0;
      end else begin
         if (any_elig) grants_q <= grants_q + 32'd1;
         if (stall)    stalls_q <= stalls_q + 32'd1;
      end
   end

   assign bus.perf_grants = grants_q;
   assign bus.perf_stalls = stalls_q;
`else
   assign bus.perf_grants = '0;
   assign bus.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_dma_arbiter.sv
// Randomized scoreboard bench for dma_arbiter; a transaction-level model predicts
// grants, read returns, error flag and counters, and a monitor compares each cycle.
module tb_dma_arbiter;
   localparam int N  = 4;
   localparam int AW = 14;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dma_arbiter_if #(.NUM_PORTS(N)) bus ();
   dma_arbiter #(.NUM_PORTS(N), .AW(AW), .READ_LAT(RL)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { int cyc; logic [N-1:0] gnt; logic err; logic [31:0] pg; logic [31:0] ps; } st_t;
   typedef struct { int cyc; int port; logic [63:0] data; } rd_t;

   st_t sq[$];
   rd_t rq[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;

   bit          pend[N], stale[N], p_we[N];
   logic [47:0] p_addr[N];
   logic [63:0] p_wd[N];
   int          last_gnt[N], due[N];
   int          ptr_m;
   bit          err_m, rand_mode, clr_req;
   logic [31:0] pg_m, ps_m;
   logic [63:0] mem_m [int];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_reset();
      for (int p = 0; p < N; p++) begin
         pend[p] = 0; stale[p] = 0; last_gnt[p] = -100; due[p] = -100;
      end
      ptr_m = N - 1; err_m = 0; pg_m = 0; ps_m = 0; clr_req = 0;
      sq.delete(); rq.delete();
      bus.arb_req = '0; bus.arb_we = '0; bus.arb_addr = '0; bus.arb_wdata = '0; bus.err_clr = 1'b0;
   endtask

   task automatic new_op(input int p, input bit we, input logic [47:0] a, input logic [63:0] d);
      pend[p] = 1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
   endtask

   function automatic logic [47:0] rand_addr();
      logic [47:0] a;
      a = (48'($urandom_range(15)) << 3) | 48'($urandom_range(7));
      if ($urandom_range(15) == 0) a[$urandom_range(47, AW+3)] = 1'b1;
      return a;
   endfunction

   // One cycle: retire seen grants, issue new ops, drive the bus, predict the next cycle.
   task automatic step();
      logic [N-1:0]    req, we;
      logic [N*48-1:0] addr;
      logic [N*64-1:0] wd;
      int   c, w, best, ecnt, idx;
      bit   oob;
      st_t  s;
      rd_t  r;
      @(negedge clk);
      c = cyc;
      for (int p = 0; p < N; p++) begin
         stale[p] = 0;
         if (pend[p] && last_gnt[p] == c) begin
            pend[p] = 0;
            stale[p] = ($urandom_range(1) == 1);
         end
      end
      if (rand_mode) begin
         for (int p = 0; p < N; p++)
            if (!pend[p] && $urandom_range(2) == 0)
               new_op(p, bit'($urandom_range(1)), rand_addr(), {$urandom, $urandom});
         clr_req = ($urandom_range(19) == 0);
      end
      for (int p = 0; p < N; p++) begin
         req[p] = pend[p] | stale[p];
         we[p]  = p_we[p];
         addr[48*p +: 48] = p_addr[p];
         wd[64*p +: 64]   = p_wd[p];
      end
      bus.arb_req = req; bus.arb_we = we; bus.arb_addr = addr; bus.arb_wdata = wd;
      bus.err_clr = clr_req;

      w = -1; best = N; ecnt = 0;
      for (int p = 0; p < N; p++) begin
         if (req[p] && last_gnt[p] != c && c >= due[p]) begin
            ecnt++;
            if ((p - ptr_m - 1 + N) % N < best) begin
               best = (p - ptr_m - 1 + N) % N;
               w = p;
            end
         end
      end
      s.cyc = c + 1;
      s.gnt = '0;
      if (w >= 0) begin
         s.gnt[w] = 1'b1; last_gnt[w] = c + 1; ptr_m = w; pg_m = pg_m + 1;
         oob = (p_addr[w] >> (AW + 3)) != 0;
         idx = int'(p_addr[w][AW+2:3]);
         if (p_we[w]) begin
            if (!oob) mem_m[idx] = p_wd[w];
         end else begin
            r.cyc = c + 1 + RL; r.port = w;
            r.data = oob ? 64'd0 : (mem_m.exists(idx) ? mem_m[idx] : 64'd0);
            rq.push_back(r);
            due[w] = c + 1 + RL;
         end
         if (oob) err_m = 1;
         else if (clr_req) err_m = 0;
      end else if (clr_req) begin
         err_m = 0;
      end
      if (ecnt > 1) ps_m = ps_m + 1;
      s.err = err_m;
`ifdef DMA_ARB_PERF_EN
      s.pg = pg_m; s.ps = ps_m;
`else
      s.pg = '0; s.ps = '0;
`endif
      sq.push_back(s);
   endtask

   task automatic run_idle();
      int b;
      bit busy;
      b = 0;
      do begin
         step();
         busy = 0;
         for (int p = 0; p < N; p++) if (pend[p] || due[p] >= cyc) busy = 1;
         b++;
      end while (busy && b < 300);
      if (busy) begin
         miscompares++;
         $display("FAIL idle_timeout cyc=%0d got still busy, exp idle within 300 cycles", cyc);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   st_t mon_s;
   rd_t mon_r;
   always @(negedge clk) begin
      if (rst) begin
         vectors++;
         if (bus.arb_gnt !== '0 || bus.arb_valid !== '0 || bus.arb_rdata !== 64'd0 ||
             bus.err_oob !== 1'b0 || bus.perf_grants !== 32'd0 || bus.perf_stalls !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outs cyc=%0d got gnt=%b valid=%b rdata=%h err=%b pg=%0d ps=%0d exp all zero",
                     cyc, bus.arb_gnt, bus.arb_valid, bus.arb_rdata, bus.err_oob, bus.perf_grants, bus.perf_stalls);
         end
      end else begin
         while (sq.size() > 0 && sq[0].cyc < cyc) begin
            mon_s = sq.pop_front();
            miscompares++;
            $display("FAIL state_skipped cyc=%0d got no check, exp check at cyc=%0d", cyc, mon_s.cyc);
         end
         if (sq.size() > 0 && sq[0].cyc == cyc) begin
            mon_s = sq.pop_front();
            vectors++;
            if (bus.arb_gnt !== mon_s.gnt || bus.err_oob !== mon_s.err ||
                bus.perf_grants !== mon_s.pg || bus.perf_stalls !== mon_s.ps) begin
               miscompares++;
               $display("FAIL state cyc=%0d got gnt=%b err=%b pg=%0d ps=%0d exp gnt=%b err=%b pg=%0d ps=%0d",
                        cyc, bus.arb_gnt, bus.err_oob, bus.perf_grants, bus.perf_stalls,
                        mon_s.gnt, mon_s.err, mon_s.pg, mon_s.ps);
            end
         end
         if (bus.arb_valid !== '0 || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
            vectors++;
            if (rq.size() == 0 || rq[0].cyc != cyc) begin
               miscompares++;
               $display("FAIL read_timing cyc=%0d got valid=%b exp valid at cyc=%0d",
                        cyc, bus.arb_valid, (rq.size() > 0) ? rq[0].cyc : -1);
               if (rq.size() > 0 && rq[0].cyc < cyc) mon_r = rq.pop_front();
            end else begin
               mon_r = rq.pop_front();
               if (bus.arb_valid !== (N'(1) << mon_r.port) || bus.arb_rdata !== mon_r.data) begin
                  miscompares++;
                  $display("FAIL read_data cyc=%0d got valid=%b rdata=%h exp port=%0d rdata=%h",
                           cyc, bus.arb_valid, bus.arb_rdata, mon_r.port, mon_r.data);
               end
            end
         end
      end
   end

   initial begin
      int nr, nw, budget;
      logic [31:0] exp_pg;
      rand_mode = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         new_op(i % N, 1'b1, 48'(i * 8), {$urandom, $urandom});
         run_idle();
      end

      new_op(0, 1'b1, 48'h40, 64'hDEAD_BEEF_0000_0001);
      run_idle();
      new_op(0, 1'b0, 48'h40, 64'd0);
      run_idle();

      do_reset();
      for (int p = 0; p < N; p++) new_op(p, 1'b0, 48'(p * 8 + 8), 64'd0);
      run_idle();

      do_reset();
      nr = 0; nw = 0; budget = 400;
      while ((nr < 8 || nw < 8) && budget > 0) begin
         if (!pend[2] && cyc >= due[2] && nr < 8) begin
            new_op(2, 1'b0, 48'($urandom_range(15) * 8), 64'd0); nr++;
         end
         if (!pend[1] && nw < 8) begin
            new_op(1, 1'b1, 48'($urandom_range(15) * 8), {$urandom, $urandom}); nw++;
         end
         step();
         budget--;
      end
      run_idle();
      vectors++;
`ifdef DMA_ARB_PERF_EN
      exp_pg = 32'd16;
`else
      exp_pg = 32'd0;
`endif
      if (bus.perf_grants !== exp_pg) begin
         miscompares++;
         $display("FAIL stream_grants got %0d exp %0d", bus.perf_grants, exp_pg);
      end

      new_op(0, 1'b0, 48'(1) << (AW + 3), 64'd0);
      run_idle();
      repeat (3) step();
      clr_req = 1;
      step();
      clr_req = 0;
      step();
      vectors++;
      if (bus.err_oob !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear got %b exp 0", bus.err_oob);
      end

      new_op(0, 1'b0, 48'h40, 64'd0);
      budget = 50;
      while (pend[0] && budget > 0) begin step(); budget--; end
      do_reset();
      repeat (6) step();
      new_op(0, 1'b0, 48'h48, 64'd0);
      new_op(3, 1'b0, 48'h50, 64'd0);
      run_idle();

      do_reset();
      rand_mode = 1;
      repeat (3000) step();
      rand_mode = 0;
      clr_req = 0;
      run_idle();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Responder end of the core memory request interface (`arb_req`/`arb_gnt`/`arb_valid`) used by each `ntt_engine`. Arbitrates `NUM_PORTS` initiators round-robin onto a single-ported 64-bit on-chip memory, commits writes, and returns read data after a fixed pipeline latency. Sits between the NTT core array and shared DMA memory.

## Interface
- `NUM_PORTS`, default 4: number of initiator ports (2..8).
- `AW`, default 14: memory word-address width; depth = 2^AW 64-bit words.
- `READ_LAT`, default 2: cycles from the `gnt` cycle to the `valid` cycle (1..4).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `arb_req` in NUM_PORTS: per-port request, level.
- `arb_we` in NUM_PORTS: per-port write enable, qualified by `arb_req`.
- `arb_addr` in NUM_PORTS*48: per-port byte address; port p occupies bits [48p+47:48p].
- `arb_wdata` in NUM_PORTS*64: per-port write data.
- `arb_gnt` out NUM_PORTS: one-cycle grant pulse, registered.
- `arb_valid` out NUM_PORTS: one-cycle read-data-valid pulse, registered.
- `arb_rdata` out 64: read data shared by all ports; meaningful only while that port's `arb_valid` is high.
- `err_oob` out 1: sticky out-of-range flag.
- `err_clr` in 1: synchronous clear of `err_oob`.
- `perf_grants` out 32: total grants issued.
- `perf_stalls` out 32: cycles where any eligible request was not granted.

## Operation
- Word index = `addr[AW+2:3]`; `addr[2:0]` is ignored. Address is out of range when `addr[47:AW+3]` != 0.
- Eligibility of port p in a cycle: `arb_req[p]`=1, p not granted in the previous cycle (its `gnt` is still high), and p has no read in flight.
- Round-robin: a pointer holds the last granted port. Search starts at pointer+1 mod NUM_PORTS. At most one grant per cycle. Pointer updates only on a grant.
- At the grant edge, the selected port's `we`, `addr`, and `wdata` are captured and the operation executes:
  - In-range write: memory is written at that edge. No `valid` is returned for writes.
  - In-range read: memory is read. Data plus the port id enter a READ_LAT-deep pipeline.
  - Out-of-range write: dropped; `err_oob` is set.
  - Out-of-range read: returns 0 with a normal `valid`; `err_oob` is set.
- A read issued after a write to the same word returns the new data, including when the read is granted in the very next cycle.
- `err_oob` set and `err_clr` in the same cycle: set wins.
- Memory contents are not reset.

## Timing
- Cycle k: `arb_req[p]` is first seen eligible. Edge k+1: `arb_gnt[p]`=1 for exactly one cycle and the operation is committed.
- Initiators hold `req`/`addr`/`we`/`wdata` until they see `gnt`. They may still present `req` during the `gnt` cycle; that cycle is never re-granted.
- Read: `arb_valid[p]` and `arb_rdata` are high for exactly cycle k+1+READ_LAT. One valid per read, delivered in order.
- Minimum grant spacing is 1 cycle across ports and 2 cycles for the same port's writes. Same-port reads are limited by the one-in-flight rule: next grant no earlier than the cycle after `valid`.
- Reset values: `arb_gnt`=0, `arb_valid`=0, `arb_rdata`=0, `err_oob`=0, counters 0, pointer = NUM_PORTS-1 (so port 0 has first priority), read pipeline empty.
- Reset asserted mid-operation: in-flight reads are discarded and produce no `valid` after reset. A write committed before reset is kept.
- `arb_rdata` holds its last value when no `valid` is asserted.

## Configuration
- `DMA_ARB_PERF_EN` defined:
  - `perf_grants` increments on every grant.
  - `perf_stalls` increments in every cycle where any eligible port exists and at least one eligible port is not granted, i.e. eligible count > granted count.
  - Both counters wrap at 2^32.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Write 0xDEAD_BEEF_0000_0001 to addr 0x40 on port 0, then read addr 0x40 on port 0 -> `gnt` 1 cycle after each request, `valid[0]` exactly 2 cycles after the read `gnt` (READ_LAT=2), `rdata`=0xDEAD_BEEF_0000_0001, no `valid` for the write.
- Ports 0-3 each hold a read request from the same cycle after reset -> grants in order 0,1,2,3 on consecutive cycles. Each port gets exactly one `gnt` even though its `req` is still high during its `gnt` cycle. Valids arrive in order 0,1,2,3.
- Port 2 streams 8 reads (wait-for-valid between requests) while port 1 streams writes -> writes interleave between port 2's reads, no double grant, `perf_grants`=16 with the macro defined.
- Read addr 1<<(AW+3) -> `valid` with `rdata`=0, `err_oob`=1 and stays 1. Assert `err_clr` -> `err_oob`=0 next cycle.
- Assert `rst` one cycle after a read `gnt` -> no `valid` after reset. All outputs are 0 during reset. After release, the first request goes to port 0 when ports 0 and 3 request together.
- Build without `DMA_ARB_PERF_EN` and run the contention test -> `perf_grants`=`perf_stalls`=0 throughout.
